// File: rtl/link_master_fsm.sv
// link_master_fsm: burst master driving a 4-phase req/ack link, with per-edge ack timeout.
module link_master_fsm #(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] base,
    input  logic       ack,
    output logic       req,
    output logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] sent_count
);
    typedef enum logic [2:0] {IDLE, REQ_HI, WAIT_LO, DONE, ABORT} state_t;

    state_t     state, nxt;
    logic [7:0] wcnt, wcnt_nxt, data_nxt;
    logic [3:0] cnt_nxt;
    logic       expired, last;

    assign expired = wcnt == 8'(TIMEOUT - 1);
    assign last    = sent_count == 4'(BURST_LEN - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req        <= 1'b0;
            data       <= 8'h00;
            sent_count <= 4'd0;
            wcnt       <= 8'd0;
        end else begin
            state      <= nxt;
            req        <= nxt == REQ_HI;
            data       <= data_nxt;
            sent_count <= cnt_nxt;
            wcnt       <= wcnt_nxt;
        end
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? REQ_HI : IDLE;
            REQ_HI:  nxt = ack ? WAIT_LO : expired ? ABORT : REQ_HI;
            WAIT_LO: nxt = !ack ? (last ? DONE : REQ_HI) : expired ? ABORT : WAIT_LO;
            default: nxt = IDLE;
        endcase
    end

    // wait counter only runs while parked in a handshake state; any transition clears it
    always_comb begin
        busy     = state != IDLE;
        done     = state == DONE;
        err      = state == ABORT;
        wcnt_nxt = (nxt == state && (state == REQ_HI || state == WAIT_LO)) ? wcnt + 8'd1 : 8'd0;
        cnt_nxt  = (state == IDLE && start) ? 4'd0
                 : (state == WAIT_LO && !ack) ? sent_count + 4'd1 : sent_count;
        data_nxt = (state == IDLE && start) ? base
                 : (state == WAIT_LO && !ack && !last) ? data + 8'd1 : data;
    end
endmodule

// File: doc/link_master_fsm.md
LINK_MASTER_FSM -- requirements
Module: link_master_fsm

Interface
REQ-001 Parameter BURST_LEN, default 4, SHALL set the number of bytes sent per burst; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles spent waiting on any single ack edge; legal range 2..255.
REQ-003 The port list SHALL be exactly as follows; the design has one clock, and reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock; all flops on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  burst request; sampled only in IDLE.
REQ-007 base  input  8  first data byte of the burst; captured on the accepted start.
REQ-008 ack  input  1  responder acknowledge (4-phase handshake).
REQ-009 req  output  1  request to the responder; registered.
REQ-010 data  output  8  byte on the link; registered; valid whenever req=1.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse marking successful burst completion.
REQ-013 err  output  1  one-cycle pulse marking a timeout abort.
REQ-014 sent_count  output  4  number of bytes fully handshaken in the current or last burst.

Function
REQ-015 The FSM SHALL have states IDLE, REQ_HI, WAIT_LO, DONE and ABORT.
REQ-016 IDLE: when start=1 at a clock edge, the FSM SHALL load data<=base and sent_count<=0, and enter REQ_HI with req=1 on the next cycle (latency 1).
REQ-017 REQ_HI: req=1 with data held stable; when ack=1 is sampled, the FSM SHALL enter WAIT_LO with req=0 on the next cycle.
REQ-018 WAIT_LO: req=0 with data held; when ack=0 is sampled, sent_count SHALL increment.
REQ-019 WAIT_LO exit, final byte: if sent_count (pre-increment) equals BURST_LEN-1, the FSM SHALL go to DONE.
REQ-020 WAIT_LO exit, otherwise: the FSM SHALL set data<=data+1 (8-bit, wrapping FF->00) and return to REQ_HI.
REQ-021 DONE SHALL assert done=1 for exactly one cycle and then enter IDLE.
REQ-022 A wait counter SHALL clear on every entry to REQ_HI or WAIT_LO and increment each cycle the awaited ack level is absent.
REQ-023 If the wait counter reaches TIMEOUT-1 without the awaited level, the FSM SHALL enter ABORT.
REQ-024 ABORT SHALL force req=0, assert err=1 for exactly one cycle, keep sent_count unchanged, and then enter IDLE.
REQ-025 start SHALL be ignored while busy=1; base changes after acceptance SHALL have no effect.
REQ-026 ack=1 in IDLE, DONE or ABORT SHALL be ignored.
REQ-027 If ack is already 1 on entry to REQ_HI, it SHALL be treated as the acknowledge (advance on the next edge).
REQ-028 done and err SHALL never be asserted in the same cycle.
REQ-029 start=1 in the DONE or ABORT cycle SHALL be ignored; a new burst needs start=1 while in IDLE.
REQ-030 req SHALL never rise while ack=1 is being sampled in WAIT_LO; a new req rises only after ack=0 is observed.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, req=0, data=0x00, busy=0, done=0, err=0, sent_count=0, and wait counter=0.
REQ-032 Reset asserted mid-burst SHALL drop req asynchronously with no done or err pulse.
REQ-033 After reset release, the block SHALL stay in IDLE until start=1.

Verification
REQ-034 Nominal burst: BURST_LEN=4, base=0xA0, start pulse, responder holding ack 2 cycles then dropping it after req falls -> data sequence A0,A1,A2,A3, each stable while req=1; sent_count ends at 4; one done pulse; err never asserted.
REQ-035 Wrap-around: base=0xFE, BURST_LEN=4 -> data sequence FE,FF,00,01; done=1 once.
REQ-036 Timeout on ack rise: ack tied 0, TIMEOUT=15 -> req high for 15 cycles, then req=0, err=1 for one cycle, sent_count=0, back to IDLE.
REQ-037 Timeout on ack fall: ack stuck at 1 after the first byte -> err pulse about 15 cycles after req falls; sent_count=0; no done pulse.
REQ-038 Reset mid-burst: rst_n=0 during the second REQ_HI -> req, busy and sent_count read 0 immediately; no pulses; a fresh start with base=0x10 then sends 10,11,12,13.
REQ-039 Start while busy: a second start pulse with base=0x55 during the burst -> ignored, the original sequence completes unchanged, and exactly one done pulse is seen.
